// File: rtl/bcd_conv_arbiter.sv
// bcd_conv_arbiter: round-robin sharing of one external binary-to-BCD
// converter among NUM_REQ requesters. Each accepted operand is held on
// conv_in for CONV_LAT cycles. The sampled BCD is then returned with the
// requester index, and is saturated to 9999 when the operand does not fit
// in four BCD digits.
module bcd_conv_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int ID_W     = 2,
  parameter int CONV_LAT = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [16*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]    req_ready,
  output logic [15:0]           conv_in,
  input  logic [15:0]           conv_out,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [ID_W-1:0]       rsp_id,
  output logic [15:0]           rsp_bcd,
  output logic                  rsp_ovf,
  output logic                  busy
);

  typedef enum logic [1:0] {IDLE, CONVERT, RESPOND} state_t;

  state_t          state;
  logic [ID_W-1:0] ptr;
  logic [ID_W-1:0] cur_id;
  logic [15:0]     op;
  logic [3:0]      wait_cnt;
  logic            grant_found;
  logic [ID_W-1:0] grant_idx;

  // Four BCD digits cannot represent anything above 9999.
  function automatic logic is_ovf(input logic [15:0] v);
    return v > 16'd9999;
  endfunction

  // Saturate the converter result when the operand is out of range.
  function automatic logic [15:0] sat_bcd(input logic [15:0] v, input logic [15:0] bcd);
    return is_ovf(v) ? 16'h9999 : bcd;
  endfunction

  // Round-robin search from ptr upward; the lowest offset that is valid wins.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req_valid[(int'(ptr) + k) % NUM_REQ]) begin
        grant_found = 1'b1;
        grant_idx   = ID_W'((int'(ptr) + k) % NUM_REQ);
      end
    end
  end

  // Accept strobe is offered only in IDLE and never while reset is asserted.
  always_comb begin
    req_ready = '0;
    if (rst_n && state == IDLE && grant_found)
      req_ready = NUM_REQ'(1) << grant_idx;
  end

  assign conv_in = op;
  assign busy    = (state != IDLE);

  // Main control FSM: accept, hold the operand for the settle window, respond.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= '0;
      cur_id    <= '0;
      op        <= '0;
      wait_cnt  <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_bcd   <= '0;
      rsp_ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_found) begin
            op       <= req_data[16*grant_idx +: 16];
            cur_id   <= grant_idx;
            wait_cnt <= 4'(CONV_LAT - 1);
            ptr      <= (int'(grant_idx) == NUM_REQ - 1) ? '0 : grant_idx + 1'b1;
            state    <= CONVERT;
          end
        end
        CONVERT: begin
          if (wait_cnt == 4'd0) begin
            rsp_bcd   <= sat_bcd(op, conv_out);
            rsp_ovf   <= is_ovf(op);
            rsp_id    <= cur_id;
            rsp_valid <= 1'b1;
            state     <= RESPOND;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        RESPOND: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_conv_arbiter.sv
// Self-checking bench for bcd_conv_arbiter. Instance a uses CONV_LAT=1 and
// instance b uses CONV_LAT=4 for the mid-operation reset scenario. Both
// instances see an ideal converter model on conv_out.
module tb_bcd_conv_arbiter;
  localparam int N   = 4;
  localparam int IDW = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst_n, rsp_ready, rsp_valid, rsp_ovf, busy;
  logic [N-1:0]   req_valid, req_ready;
  logic [16*N-1:0] req_data;
  logic [15:0]    conv_in, conv_out, rsp_bcd;
  logic [IDW-1:0] rsp_id;

  logic           rst_nb, rsp_ready_b, rsp_valid_b, rsp_ovf_b, busy_b;
  logic [N-1:0]   req_valid_b, req_ready_b;
  logic [16*N-1:0] req_data_b;
  logic [15:0]    conv_in_b, conv_out_b, rsp_bcd_b;
  logic [IDW-1:0] rsp_id_b;

  int checks   = 0;
  int failures = 0;
  int m_ptr    = 0;

  // Ideal converter: decimal digits of the low four decimal places.
  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  // Expected response BCD, saturated above 9999.
  function automatic logic [15:0] exp_bcd(input int v);
    return (v > 9999) ? 16'h9999 : to_bcd(v);
  endfunction

  function automatic int from_bcd(input logic [15:0] b);
    return int'(b[15:12]) * 1000 + int'(b[11:8]) * 100 + int'(b[7:4]) * 10 + int'(b[3:0]);
  endfunction

  assign conv_out   = to_bcd(int'(conv_in));
  assign conv_out_b = to_bcd(int'(conv_in_b));

  bcd_conv_arbiter #(.NUM_REQ(N), .ID_W(IDW), .CONV_LAT(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .conv_in(conv_in), .conv_out(conv_out),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_bcd(rsp_bcd), .rsp_ovf(rsp_ovf), .busy(busy));

  bcd_conv_arbiter #(.NUM_REQ(N), .ID_W(IDW), .CONV_LAT(4)) dut_b (
    .clk(clk), .rst_n(rst_nb), .req_valid(req_valid_b), .req_data(req_data_b),
    .req_ready(req_ready_b), .conv_in(conv_in_b), .conv_out(conv_out_b),
    .rsp_valid(rsp_valid_b), .rsp_ready(rsp_ready_b), .rsp_id(rsp_id_b),
    .rsp_bcd(rsp_bcd_b), .rsp_ovf(rsp_ovf_b), .busy(busy_b));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one request on instance a and collect its response (no checking here).
  task automatic run_one(input int i, input logic [15:0] d,
                         output logic [IDW-1:0] id, output logic [15:0] bcd,
                         output logic ovf, output int lat,
                         output logic [N-1:0] rdy_after, output bit to);
    bit acc;
    acc = 1'b0; to = 1'b0; lat = 0; id = '0; bcd = '0; ovf = 1'b0; rdy_after = '0;
    rsp_ready = 1'b1;
    req_data[16*i +: 16] = d;
    req_valid[i] = 1'b1;
    for (int n = 0; n < 50 && !acc; n++) begin
      #1;
      if (req_ready[i]) acc = 1'b1;
      tick();
    end
    req_valid[i] = 1'b0;
    if (!acc) begin to = 1'b1; return; end
    m_ptr = (i + 1) % N;
    rdy_after = req_ready;
    while (!rsp_valid && lat < 50) begin tick(); lat++; end
    if (!rsp_valid) begin to = 1'b1; return; end
    id = rsp_id; bcd = rsp_bcd; ovf = rsp_ovf;
    tick();
  endtask

  // Present several requests at once and record responses in arrival order.
  task automatic run_batch(input logic [N-1:0] mask, input logic [16*N-1:0] data,
                           output logic [N*IDW-1:0] ids, output logic [16*N-1:0] bcds,
                           output int cnt);
    logic [N-1:0] acc;
    int want;
    want = $countones(mask);
    ids = '0; bcds = '0; cnt = 0;
    rsp_ready = 1'b1;
    req_data  = data;
    req_valid = mask;
    for (int n = 0; n < 200 && cnt < want; n++) begin
      #1;
      if (rsp_valid) begin
        ids[IDW*cnt +: IDW] = rsp_id;
        bcds[16*cnt +: 16]  = rsp_bcd;
        cnt++;
      end
      acc = req_ready;
      tick();
      req_valid = req_valid & ~acc;
    end
    req_valid = '0;
  endtask

  task automatic test_reset();
    req_valid = '1; req_valid_b = '1;
    #1;
    checks++; if (req_ready !== 4'b0000) begin failures++; $display("FAIL reset_req_ready got=%b want=0000", req_ready); end
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL reset_rsp_valid got=%b want=0", rsp_valid); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b want=0", busy); end
    checks++; if (conv_in !== 16'h0000) begin failures++; $display("FAIL reset_conv_in got=%h want=0000", conv_in); end
    checks++; if (rsp_bcd !== 16'h0000) begin failures++; $display("FAIL reset_rsp_bcd got=%h want=0000", rsp_bcd); end
    checks++; if (rsp_id !== 2'd0) begin failures++; $display("FAIL reset_rsp_id got=%0d want=0", rsp_id); end
    checks++; if (rsp_ovf !== 1'b0) begin failures++; $display("FAIL reset_rsp_ovf got=%b want=0", rsp_ovf); end
    checks++; if (req_ready_b !== 4'b0000 || busy_b !== 1'b0) begin failures++; $display("FAIL reset_b got ready=%b busy=%b want 0000/0", req_ready_b, busy_b); end
    req_valid = '0; req_valid_b = '0;
    rst_n = 1'b1; rst_nb = 1'b1;
    m_ptr = 0;
    tick();
  endtask

  task automatic test_single();
    logic [IDW-1:0] id; logic [15:0] bcd; logic ovf; int lat; logic [N-1:0] ra; bit to;
    run_one(0, 16'd1234, id, bcd, ovf, lat, ra, to);
    checks++; if (to) begin failures++; $display("FAIL single_timeout got=timeout want=response"); end
    checks++; if (bcd !== 16'h1234) begin failures++; $display("FAIL single_bcd got=%h want=1234", bcd); end
    checks++; if (id !== 2'd0) begin failures++; $display("FAIL single_id got=%0d want=0", id); end
    checks++; if (ovf !== 1'b0) begin failures++; $display("FAIL single_ovf got=%b want=0", ovf); end
    checks++; if (lat != 1) begin failures++; $display("FAIL single_latency got=%0d want=1", lat); end
    checks++; if (ra !== 4'b0000) begin failures++; $display("FAIL single_ready_after got=%b want=0000", ra); end
    checks++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL single_done got valid=%b busy=%b want 0/0", rsp_valid, busy); end
  endtask

  task automatic test_sweep();
    logic [IDW-1:0] id; logic [15:0] bcd; logic ovf; int lat; logic [N-1:0] ra; bit to;
    for (int v = 0; v <= 9999; v++) begin
      run_one(2, 16'(v), id, bcd, ovf, lat, ra, to);
      checks++;
      if (to || id !== 2'd2 || ovf !== 1'b0 || from_bcd(bcd) != v || bcd !== exp_bcd(v) || lat != 1) begin
        failures++;
        $display("FAIL sweep in=%0d got bcd=%h id=%0d ovf=%b lat=%0d to=%0d want bcd=%h id=2 ovf=0 lat=1",
                 v, bcd, id, ovf, lat, to, exp_bcd(v));
      end
    end
  endtask

  task automatic test_ovf();
    int tbl[5] = '{9999, 10000, 65535, 10001, 32768};
    logic [IDW-1:0] id; logic [15:0] bcd; logic ovf; int lat; logic [N-1:0] ra; bit to;
    int v, i;
    for (int k = 0; k < 13; k++) begin
      v = (k < 5) ? tbl[k] : int'($urandom_range(0, 65535));
      i = int'($urandom_range(0, N - 1));
      run_one(i, 16'(v), id, bcd, ovf, lat, ra, to);
      checks++;
      if (to || bcd !== exp_bcd(v) || ovf !== (v > 9999) || int'(id) != i) begin
        failures++;
        $display("FAIL ovf in=%0d req=%0d got bcd=%h ovf=%b id=%0d want bcd=%h ovf=%b id=%0d",
                 v, i, bcd, ovf, id, exp_bcd(v), (v > 9999), i);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] d; logic [IDW-1:0] s_id; logic [15:0] s_bcd; logic s_ovf;
    bit acc; int n;
    d = 16'($urandom_range(0, 9999));
    rsp_ready = 1'b0;
    req_data[16 +: 16] = d;
    req_valid = 4'b0010;
    acc = 1'b0;
    for (n = 0; n < 50 && !acc; n++) begin #1; if (req_ready[1]) acc = 1'b1; tick(); end
    req_valid = 4'b1101;
    n = 0;
    while (!rsp_valid && n < 50) begin tick(); n++; end
    checks++;
    if (!acc || !rsp_valid) begin
      failures++; $display("FAIL bp_timeout got accept=%0d valid=%b want 1/1", acc, rsp_valid);
    end else begin
      m_ptr = 2;
      s_id = rsp_id; s_bcd = rsp_bcd; s_ovf = rsp_ovf;
      checks++;
      if (s_id !== 2'd1 || s_bcd !== exp_bcd(int'(d)) || s_ovf !== 1'b0) begin
        failures++; $display("FAIL bp_value got id=%0d bcd=%h ovf=%b want id=1 bcd=%h ovf=0", s_id, s_bcd, s_ovf, exp_bcd(int'(d)));
      end
      for (int c = 0; c < 5; c++) begin
        tick();
        checks++;
        if (rsp_valid !== 1'b1 || rsp_id !== s_id || rsp_bcd !== s_bcd || rsp_ovf !== s_ovf ||
            req_ready !== 4'b0000 || busy !== 1'b1) begin
          failures++;
          $display("FAIL bp_hold cyc=%0d got valid=%b id=%0d bcd=%h ready=%b busy=%b want 1/%0d/%h/0000/1",
                   c, rsp_valid, rsp_id, rsp_bcd, req_ready, busy, s_id, s_bcd);
        end
      end
      req_valid = '0;
      rsp_ready = 1'b1;
      tick();
      checks++;
      if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
        failures++; $display("FAIL bp_release got valid=%b busy=%b want 0/0", rsp_valid, busy);
      end
    end
  endtask

  task automatic test_contention();
    logic [N-1:0] mask, pend;
    logic [16*N-1:0] data;
    logic [N*IDW-1:0] ids; logic [16*N-1:0] bcds;
    int cnt, j, p, want;
    rst_n = 1'b0; tick(); rst_n = 1'b1; m_ptr = 0;
    for (int t = 0; t < 8; t++) begin
      if (t == 0) begin
        mask = 4'b1111; data = {16'd44, 16'd33, 16'd22, 16'd11};
      end else if (t == 1) begin
        mask = 4'b1001; data = {16'd404, 16'd0, 16'd0, 16'd101};
      end else begin
        mask = 4'($urandom_range(1, 15));
        data = {16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom)};
      end
      want = $countones(mask);
      run_batch(mask, data, ids, bcds, cnt);
      checks++;
      if (cnt != want) begin failures++; $display("FAIL contention_count t=%0d got=%0d want=%0d", t, cnt, want); end
      pend = mask; p = m_ptr;
      for (int k = 0; k < want; k++) begin
        j = -1;
        for (int off = 0; off < N && j < 0; off++)
          if (pend[(p + off) % N]) j = (p + off) % N;
        pend[j] = 1'b0;
        p = (j + 1) % N;
        checks++;
        if (int'(ids[IDW*k +: IDW]) != j || bcds[16*k +: 16] !== exp_bcd(int'(data[16*j +: 16]))) begin
          failures++;
          $display("FAIL contention t=%0d slot=%0d got id=%0d bcd=%h want id=%0d bcd=%h",
                   t, k, ids[IDW*k +: IDW], bcds[16*k +: 16], j, exp_bcd(int'(data[16*j +: 16])));
        end
      end
      m_ptr = p;
    end
  endtask

  task automatic test_reset_mid();
    bit acc, seen; int n;
    rsp_ready_b = 1'b1;
    req_data_b[32 +: 16] = 16'd5678;
    req_valid_b = 4'b0100;
    acc = 1'b0;
    for (n = 0; n < 50 && !acc; n++) begin #1; if (req_ready_b[2]) acc = 1'b1; tick(); end
    req_valid_b = '0;
    checks++; if (!acc || busy_b !== 1'b1) begin failures++; $display("FAIL rmid_accept got accept=%0d busy=%b want 1/1", acc, busy_b); end
    tick();
    rst_nb = 1'b0;
    req_valid_b = 4'b1000;
    #1;
    checks++; if (req_ready_b !== 4'b0000) begin failures++; $display("FAIL rmid_ready_in_reset got=%b want=0000", req_ready_b); end
    tick();
    checks++;
    if (rsp_valid_b !== 1'b0 || busy_b !== 1'b0 || conv_in_b !== 16'h0000 || rsp_bcd_b !== 16'h0000 ||
        rsp_id_b !== 2'd0 || rsp_ovf_b !== 1'b0) begin
      failures++;
      $display("FAIL rmid_reset_vals got valid=%b busy=%b conv_in=%h bcd=%h id=%0d ovf=%b want all zero",
               rsp_valid_b, busy_b, conv_in_b, rsp_bcd_b, rsp_id_b, rsp_ovf_b);
    end
    rst_nb = 1'b1;
    req_valid_b = '0;
    seen = 1'b0;
    for (int c = 0; c < 10; c++) begin tick(); if (rsp_valid_b) seen = 1'b1; end
    checks++; if (seen) begin failures++; $display("FAIL rmid_ghost_response got=1 want=0"); end
    req_data_b[16 +: 16] = 16'd4321;
    req_data_b[48 +: 16] = 16'd777;
    req_valid_b = 4'b1010;
    acc = 1'b0;
    for (n = 0; n < 50 && !acc; n++) begin
      #1;
      if (req_ready_b != '0) begin
        acc = 1'b1;
        checks++; if (req_ready_b !== 4'b0010) begin failures++; $display("FAIL rmid_ptr_reset got ready=%b want=0010", req_ready_b); end
      end
      tick();
    end
    req_valid_b = '0;
    n = 0;
    while (!rsp_valid_b && n < 50) begin tick(); n++; end
    checks++;
    if (!acc || !rsp_valid_b || n != 4 || rsp_id_b !== 2'd1 || rsp_bcd_b !== 16'h4321 || rsp_ovf_b !== 1'b0) begin
      failures++;
      $display("FAIL rmid_after got accept=%0d valid=%b lat=%0d id=%0d bcd=%h ovf=%b want 1/1/4/1/4321/0",
               acc, rsp_valid_b, n, rsp_id_b, rsp_bcd_b, rsp_ovf_b);
    end
    tick();
  endtask

  initial begin
    rst_n = 1'b0; rst_nb = 1'b0;
    req_valid = '0; req_data = '0; rsp_ready = 1'b1;
    req_valid_b = '0; req_data_b = '0; rsp_ready_b = 1'b1;
    tick(); tick();
    test_reset();
    test_single();
    test_sweep();
    test_ovf();
    test_backpressure();
    test_contention();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/bcd_conv_arbiter.md
# bcd_conv_arbiter

Shares one combinational `convert_to_bcd` instance (16-bit binary in, 4-digit packed BCD out) among NUM_REQ requesters. Requesters submit operands over a valid/ready handshake. A round-robin arbiter grants one request at a time, holds the operand on the converter for a fixed settle window, and captures the result. The result is returned on a single response channel tagged with the requester index. The block sits between the display/telemetry producers and the shared converter, and also flags operands that do not fit in four BCD digits.

## Interface
- NUM_REQ, 4: number of requesters (2..8).
- ID_W, 2: width of rsp_id; must satisfy 2**ID_W >= NUM_REQ.
- CONV_LAT, 1: cycles the operand is held on conv_in before conv_out is sampled (1..15).
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- req_valid  in  NUM_REQ  bit i = requester i has an operand.
- req_data  in  16*NUM_REQ  operand of requester i in bits [16i+15:16i].
- req_ready  out  NUM_REQ  one-hot or zero; bit i = request i accepted this edge.
- conv_in  out  16  operand driven to the shared converter.
- conv_out  in  16  packed BCD from the converter (thousands in [15:12] … units in [3:0]).
- rsp_valid  out  1  response available.
- rsp_ready  in  1  consumer accepts the response.
- rsp_id  out  ID_W  index of the requester this response belongs to.
- rsp_bcd  out  16  packed BCD result.
- rsp_ovf  out  1  operand was > 9999; rsp_bcd is saturated.
- busy  out  1  high whenever state != IDLE.

## Operation
- FSM states: IDLE, CONVERT, RESPOND.
- IDLE
  - The grant index g is the first i with req_valid[i] = 1, searched from the round-robin pointer ptr upward, modulo NUM_REQ.
  - req_ready[g] is asserted combinationally and only in IDLE. All other bits are 0.
  - On the accept edge, the block latches op = req_data[g] and id = g, loads wait_cnt = CONV_LAT-1, sets ptr = (g+1) mod NUM_REQ, and moves to CONVERT.
  - With no valid request, the block stays in IDLE and ptr is unchanged.
- CONVERT
  - conv_in = op, held stable.
  - wait_cnt decrements each cycle.
  - On the edge where wait_cnt == 0:
    - rsp_bcd = conv_out, or 16'h9999 if op > 9999.
    - rsp_ovf = (op > 9999).
    - rsp_id = id.
    - rsp_valid goes to 1 and the FSM moves to RESPOND.
- RESPOND
  - rsp_valid, rsp_id, rsp_bcd and rsp_ovf are held stable until the edge where rsp_valid && rsp_ready; then the FSM returns to IDLE and rsp_valid goes to 0.
  - req_ready is all-zero throughout RESPOND, so backpressure stalls all requesters.
- Overflow check is an unsigned compare on the full 16 bits; 9999 is not an overflow, 10000 is.
- conv_in holds the last op in all states; no glitching to 0 between requests.
- Requester inputs are sampled only on the accept edge. Changes to req_data[i] while i is not being granted have no effect.

## Timing
- Reset values (rst_n = 0 at a rising edge):
  - state = IDLE, ptr = 0, op = 0 (so conv_in = 0), wait_cnt = 0.
  - rsp_valid = 0, rsp_id = 0, rsp_bcd = 16'h0000, rsp_ovf = 0, busy = 0.
  - req_ready = 0 during the reset cycle.
- Latency: if a request is accepted at edge E, rsp_valid is high after edge E+CONV_LAT.
- Minimum spacing between accepts is CONV_LAT+2 cycles, given rsp_ready = 1:
  - E: accept.
  - E+CONV_LAT: response valid.
  - E+CONV_LAT+1: response handshake; back to IDLE.
  - E+CONV_LAT+2: next accept.
- A request arriving during CONVERT or RESPOND waits. req_valid must stay high until req_ready; dropping it early forfeits the slot without error.
- Reset mid-operation (CONVERT or RESPOND) discards the in-flight request. No response is ever emitted for it, and ptr returns to 0.
- Fairness: with all requesters continuously valid, grants cycle 0,1,…,NUM_REQ-1,0,…; no requester waits more than NUM_REQ-1 grants.

## Test plan
- Single request: requester 0 sends 1234, CONV_LAT = 1, rsp_ready = 1.
  - Expect req_ready[0] for exactly one cycle.
  - Expect rsp_valid 1 cycle after the accept, with rsp_bcd = 16'h1234, rsp_id = 0, rsp_ovf = 0.
- Sweep: requester 2 sends 0..9999 back-to-back. Each response must reconstruct to the input, i.e. d3*1000 + d2*100 + d1*10 + d0 = in. Spot values: 0 → 16'h0000, 9 → 16'h0009, 10 → 16'h0010.
- Overflow boundary:
  - 9999 → rsp_bcd 16'h9999, rsp_ovf 0.
  - 10000 → rsp_bcd 16'h9999, rsp_ovf 1.
  - 65535 → rsp_bcd 16'h9999, rsp_ovf 1.
- Contention: all 4 requesters valid at once with data 11, 22, 33, 44.
  - Responses arrive in order id 0, 1, 2, 3 with BCD 16'h0011, 16'h0022, 16'h0033, 16'h0044.
  - Then 0 and 3 re-request while ptr = 0: grant order is 0 then 3.
- Backpressure: hold rsp_ready = 0 for 5 cycles during RESPOND.
  - rsp_* stays stable, req_ready stays 0, busy stays 1.
  - The response completes on the first cycle with rsp_ready = 1.
- Reset mid-operation: assert rst_n = 0 for one cycle while in CONVERT with CONV_LAT = 4.
  - No rsp_valid appears for that request.
  - All outputs take their reset values.
  - A new request from requester 1 afterwards completes normally.
